snake_cmd: RTL



---
 rtl/snake_cmd_pkg.sv | 27 ++
 rtl/cmd_fifo.sv | 64 ++++++
 rtl/snake_cmd.sv | 123 ++++++++++++
 3 files changed

// File: rtl/snake_cmd_pkg.sv
// rtl/snake_cmd_pkg.sv - shared command, heading and state codes for the snake command stage
package snake_cmd_pkg;

  localparam logic [3:0] CMD_UP      = 4'h1;
  localparam logic [3:0] CMD_RIGHT   = 4'h2;
  localparam logic [3:0] CMD_DOWN    = 4'h3;
  localparam logic [3:0] CMD_LEFT    = 4'h4;
  localparam logic [3:0] CMD_PAUSE   = 4'h8;
  localparam logic [3:0] CMD_RESTART = 4'h9;

  // Heading codes are also used by the snake engine.
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_e;

  // Opposite headings differ only in the top bit with this encoding.
  function automatic logic is_reversal(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - first-word fall-through synchronous FIFO with flush
module cmd_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop, do_push;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/snake_cmd.sv
// rtl/snake_cmd.sv - decodes board writes into heading, step, pause and restart for the snake engine
module snake_cmd
  import snake_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] board_data,
  input  logic       board_wr,
  output logic [1:0] dir,
  output logic       step,
  output logic       restart,
  output logic       paused,
  output logic [7:0] drop_cnt
);

  localparam int            CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dir_q, dir_d;
  logic          step_q, step_d;
  logic          restart_q, restart_d;
  logic [7:0]    drop_q, drop_d;

  logic       cmd_dir, cmd_pause, cmd_restart;
  logic [1:0] cmd_heading;
  logic       tick, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0] fifo_dout;

  always_comb begin
    cmd_dir     = 1'b0;
    cmd_pause   = 1'b0;
    cmd_restart = 1'b0;
    cmd_heading = DIR_UP;
    if (board_wr) begin
      case (board_data)
        CMD_UP:      begin cmd_dir = 1'b1; cmd_heading = DIR_UP;    end
        CMD_RIGHT:   begin cmd_dir = 1'b1; cmd_heading = DIR_RIGHT; end
        CMD_DOWN:    begin cmd_dir = 1'b1; cmd_heading = DIR_DOWN;  end
        CMD_LEFT:    begin cmd_dir = 1'b1; cmd_heading = DIR_LEFT;  end
        CMD_PAUSE:   cmd_pause   = 1'b1;
        CMD_RESTART: cmd_restart = 1'b1;
        default:     ;
      endcase
    end
  end

  // Restart pre-empts the tick, so a restart on the wrap cycle neither steps nor pops.
  assign tick      = (state_q == RUN) && (cnt_q == CNT_MAX) && !cmd_restart;
  assign fifo_pop  = tick && !fifo_empty;
  assign fifo_push = cmd_dir && (!fifo_full || fifo_pop);

  cmd_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (cmd_restart),
    .din   (cmd_heading),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    drop_d    = drop_q;
    step_d    = tick;
    restart_d = cmd_restart;
    if (cmd_restart) begin
      state_d = RUN;
      cnt_d   = '0;
      dir_d   = DIR_RIGHT;
    end else begin
      if (state_q == RUN) begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
      if (fifo_pop && !is_reversal(fifo_dout, dir_q)) begin
        dir_d = fifo_dout;
      end
      if (cmd_pause) begin
        state_d = (state_q == RUN) ? PAUSED : RUN;
      end
      if (cmd_dir && !fifo_push && drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      dir_q     <= DIR_RIGHT;
      step_q    <= 1'b0;
      restart_q <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      restart_q <= restart_d;
      drop_q    <= drop_d;
    end
  end

  assign dir      = dir_q;
  assign step     = step_q;
  assign restart  = restart_q;
  assign paused   = (state_q == PAUSED);
  assign drop_cnt = drop_q;

endmodule
